// File: rtl/asyn_fifo_wr_arb.sv
// asyn_fifo_wr_arb
// Round-robin write-port arbiter for the CDC FIFO (clk_w domain).
// A grant is held for a whole packet so each burst stays contiguous in the FIFO.
// A burst also ends after MAX_BURST beats, so a long stream cannot starve the others.
// The FIFO full flag stalls the active burst.
module asyn_fifo_wr_arb #(
    parameter int DLY        = 1,
    parameter int WIDTH_FIFO = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int MAX_BURST  = 8,
    parameter int CNT_W      = 4
) (
    input  logic                          clk_w,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*WIDTH_FIFO-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wen,
    output logic [WIDTH_FIFO-1:0]         wdata,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    // DLY only matters to behavioural simulation models. The flops below update
    // with zero delay, so DLY is used only by the parameter sanity check.
    if ((NUM_REQ < 2) || (NUM_REQ > 16) || ((1 << ID_W) < NUM_REQ) ||
        (MAX_BURST < 1) || (MAX_BURST > (1 << CNT_W) - 1) || (DLY < 0)) begin : g_bad_params
        $error("asyn_fifo_wr_arb: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_grant_id;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic [ID_W-1:0]       w_hi_idx;
    logic [ID_W-1:0]       w_lo_idx;
    logic                  w_hi_found;
    logic                  w_lo_found;
    logic [ID_W-1:0]       w_winner;
    logic [NUM_REQ-1:0]    w_gnt_onehot;
    logic                  w_gnt_valid;
    logic                  w_gnt_last;
    logic [WIDTH_FIFO-1:0] w_gnt_data;
    logic                  w_xfer;
    logic                  w_burst_end;

    // Round-robin pick: the lowest valid index above r_rr_ptr, else the lowest valid index (wrap).
    // NOTE: every signal driven in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_idx   = ID_W'(i);
                w_lo_found = 1'b1;
                if (i > int'(r_rr_ptr)) begin
                    w_hi_idx   = ID_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // Select the current grantee's valid, last and data using constant-index muxing.
    always_comb begin
        w_gnt_onehot = '0;
        w_gnt_valid  = 1'b0;
        w_gnt_last   = 1'b0;
        w_gnt_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == r_grant_id) begin
                w_gnt_onehot[i] = 1'b1;
                w_gnt_valid     = req_valid[i];
                w_gnt_last      = req_last[i];
                w_gnt_data      = req_data[i*WIDTH_FIFO +: WIDTH_FIFO];
            end
        end
    end

    assign w_xfer      = (r_state == ST_BURST) && w_gnt_valid && !full;
    assign w_burst_end = w_xfer && (w_gnt_last || (r_beat_cnt == LAST_BEAT));

    // Next-state logic and FIFO-side outputs. Writes happen only in BURST.
    always_comb begin
        w_state_nxt = r_state;
        wen         = 1'b0;
        wdata       = '0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_lo_found) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                wen       = w_xfer;
                wdata     = w_gnt_data;
                req_ready = w_xfer ? w_gnt_onehot : '0;
                if (w_burst_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register. An asynchronous reset aborts any burst in progress.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the grant at burst start. Count accepted beats while the burst is active.
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_lo_found) begin
                r_grant_id <= w_winner;
                r_rr_ptr   <= w_winner;
                r_beat_cnt <= '0;
            end
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign busy     = (r_state == ST_BURST);
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_asyn_fifo_wr_arb.sv
// Bench for asyn_fifo_wr_arb.
// The reference model is packet-level: per-requester beat stores, plus an owner, pointer and
// beat count for the write port. Directed scenarios are followed by randomized traffic.
module tb_asyn_fifo_wr_arb;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int MAXB  = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 256;

    logic           clk_w = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           full;
    logic           wen;
    logic [W-1:0]   wdata;
    logic [IDW-1:0] grant_id;
    logic           busy;

    asyn_fifo_wr_arb #(
        .DLY(1), .WIDTH_FIFO(W), .NUM_REQ(N), .ID_W(IDW), .MAX_BURST(MAXB), .CNT_W(CW)
    ) u_dut (
        .clk_w    (clk_w),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_data (req_data),
        .req_ready(req_ready),
        .full     (full),
        .wen      (wen),
        .wdata    (wdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk_w = ~clk_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Beats each requester still has to send.
    logic [W-1:0] q_dat [N][DEPTH];
    logic         q_lst [N][DEPTH];
    int           q_head [N];
    int           q_tail [N];

    // Reference model of the write-port owner.
    bit           m_busy;
    int           m_gid;
    int           m_ptr;
    int           m_beats;
    bit [N-1:0]   m_acc;

    logic [N-1:0] gate;
    int           valid_pct;

    // What the DUT actually wrote, and the grants it made.
    int           wr_n;
    int           wr_cyc [DEPTH];
    int           wr_src [DEPTH];
    logic [W-1:0] wr_dat [DEPTH];
    int           gr_n;
    int           gr_id [16];
    bit           prev_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [W-1:0] d, input logic l);
        q_dat[r][q_tail[r]] = d;
        q_lst[r][q_tail[r]] = l;
        q_tail[r]++;
    endtask

    task automatic clear_logs();
        wr_n = 0;
        gr_n = 0;
    endtask

    // Offer beats. A beat offered but not accepted stays on the bus unchanged.
    task automatic drive(input logic f);
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !m_acc[i])) begin
                if ((q_head[i] < q_tail[i]) && !gate[i] && ($urandom_range(99) < valid_pct)) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*W +: W]   = q_dat[i][q_head[i]];
                    req_last[i]          = q_lst[i][q_head[i]];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*W +: W]   = W'($urandom);
                    req_last[i]          = 1'($urandom);
                end
            end
        end
        full = f;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic step(input logic f);
        logic         exp_xfer;
        logic [W-1:0] exp_wd;
        logic [N-1:0] exp_rdy;
        int           src;
        drive(f);
        @(negedge clk_w);
        exp_xfer = m_busy && req_valid[m_gid] && !full;
        exp_wd   = m_busy ? req_data[m_gid*W +: W] : '0;
        exp_rdy  = exp_xfer ? (N'(1) << m_gid) : '0;
        check("wen",       32'(wen),       32'(exp_xfer));
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("wdata",     32'(wdata),     32'(exp_wd));
        check("busy",      32'(busy),      32'(m_busy));
        check("grant_id",  32'(grant_id),  32'(m_gid));
        if (busy && !prev_busy) begin
            if (gr_n < 16) gr_id[gr_n] = int'(grant_id);
            gr_n++;
        end
        prev_busy = busy;
        if (wen) begin
            src = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) src = i;
            if (wr_n < DEPTH) begin
                wr_cyc[wr_n] = cyc;
                wr_src[wr_n] = src;
                wr_dat[wr_n] = wdata;
            end
            wr_n++;
        end
        m_acc = '0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    m_busy  = 1'b1;
                    m_gid   = c;
                    m_ptr   = c;
                    m_beats = 0;
                    break;
                end
            end
        end else if (exp_xfer) begin
            m_acc[m_gid] = 1'b1;
            m_beats++;
            if (q_lst[m_gid][q_head[m_gid]] || (m_beats == MAXB)) m_busy = 1'b0;
            q_head[m_gid]++;
        end
        @(posedge clk_w);
        #1;
        cyc++;
    endtask

    task automatic run_until_empty(input int max_cyc, input int full_pct);
        int pend;
        for (int n = 0; n < max_cyc; n++) begin
            pend = 0;
            for (int i = 0; i < N; i++) pend += q_tail[i] - q_head[i];
            if ((pend == 0) && !m_busy) break;
            step($urandom_range(99) < full_pct);
        end
        pend = 0;
        for (int i = 0; i < N; i++) pend += q_tail[i] - q_head[i];
        check("drain", 32'(pend + int'(m_busy)), 32'd0);
    endtask

    // Reset can land anywhere in a cycle. The outputs must clear right away.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_wen",       32'(wen),       32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_wdata",     32'(wdata),     32'd0);
        check("rst_grant_id",  32'(grant_id),  32'd0);
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        full      = 1'b0;
        @(posedge clk_w);
        @(posedge clk_w);
        #1;
        rst_n     = 1'b1;
        m_busy    = 1'b0;
        m_gid     = 0;
        m_ptr     = N - 1;
        m_beats   = 0;
        m_acc     = '0;
        prev_busy = 1'b0;
        gate      = '0;
        for (int i = 0; i < N; i++) begin
            q_head[i] = 0;
            q_tail[i] = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s0;
        int total;
        int len;
        valid_pct = 100;
        #2;
        do_reset();

        // Single 3-beat packet from req0.
        clear_logs();
        s0 = cyc;
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        run_until_empty(20, 0);
        step(1'b0);
        check("single_count", 32'(wr_n), 32'd3);
        check("single_d0", 32'(wr_dat[0]), 32'h11);
        check("single_d1", 32'(wr_dat[1]), 32'h22);
        check("single_d2", 32'(wr_dat[2]), 32'h33);
        check("single_first_cyc", 32'(wr_cyc[0]), 32'(s0 + 1));
        check("single_last_cyc", 32'(wr_cyc[2]), 32'(s0 + 3));
        check("single_src", 32'(wr_src[1]), 32'd0);

        // Round-robin grants with 1-beat packets.
        do_reset();
        clear_logs();
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA4, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        run_until_empty(40, 0);
        check("rr_grants", 32'(gr_n), 32'd5);
        check("rr_g0", 32'(gr_id[0]), 32'd0);
        check("rr_g1", 32'(gr_id[1]), 32'd1);
        check("rr_g2", 32'(gr_id[2]), 32'd2);
        check("rr_g3", 32'(gr_id[3]), 32'd3);
        check("rr_g4", 32'(gr_id[4]), 32'd0);
        check("rr_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
        check("rr_d4", 32'(wr_dat[4]), 32'hA4);

        // Full stall of 3 cycles after beat 2 of a 4-beat burst from req2.
        clear_logs();
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b0);
        push(2, 8'hC3, 1'b0);
        push(2, 8'hC4, 1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        run_until_empty(20, 0);
        check("stall_count", 32'(wr_n), 32'd4);
        check("stall_d2", 32'(wr_dat[2]), 32'hC3);
        check("stall_d3", 32'(wr_dat[3]), 32'hC4);
        check("stall_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
        check("stall_src", 32'(wr_src[3]), 32'd2);

        // Burst cap: req1 streams 20 beats while req3 waits.
        clear_logs();
        for (int b = 0; b < 20; b++) push(1, 8'(8'h80 + b), b == 19);
        push(3, 8'hD3, 1'b1);
        gate = 4'b1000;
        step(1'b0);
        gate = '0;
        run_until_empty(100, 0);
        check("cap_grants", 32'(gr_n), 32'd4);
        check("cap_g0", 32'(gr_id[0]), 32'd1);
        check("cap_g1", 32'(gr_id[1]), 32'd3);
        check("cap_g2", 32'(gr_id[2]), 32'd1);
        check("cap_g3", 32'(gr_id[3]), 32'd1);
        check("cap_count", 32'(wr_n), 32'd21);
        check("cap_src7", 32'(wr_src[7]), 32'd1);
        check("cap_src8", 32'(wr_src[8]), 32'd3);
        check("cap_d8", 32'(wr_dat[8]), 32'hD3);
        check("cap_d9", 32'(wr_dat[9]), 32'h88);
        check("cap_d20", 32'(wr_dat[20]), 32'h93);

        // Valid gap: req0 drops valid for 2 cycles mid-packet while req1 waits.
        clear_logs();
        push(0, 8'hE1, 1'b0);
        push(0, 8'hE2, 1'b0);
        push(0, 8'hE3, 1'b1);
        push(1, 8'hE9, 1'b1);
        step(1'b0);
        step(1'b0);
        gate = 4'b0001;
        step(1'b0);
        step(1'b0);
        gate = '0;
        run_until_empty(30, 0);
        check("gap_grants", 32'(gr_n), 32'd2);
        check("gap_g0", 32'(gr_id[0]), 32'd0);
        check("gap_g1", 32'(gr_id[1]), 32'd1);
        check("gap_count", 32'(wr_n), 32'd4);
        check("gap_src2", 32'(wr_src[2]), 32'd0);
        check("gap_src3", 32'(wr_src[3]), 32'd1);
        check("gap_hold", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
        check("gap_d3", 32'(wr_dat[3]), 32'hE9);

        // Reset after beat 2 of a 5-beat packet.
        clear_logs();
        for (int b = 0; b < 5; b++) push(0, 8'(8'h51 + b), b == 4);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        drive(1'b0);
        #1;
        check("prerst_wen", 32'(wen), 32'd1);
        check("prerst_count", 32'(wr_n), 32'd2);
        do_reset();
        clear_logs();
        push(0, 8'h61, 1'b1);
        push(3, 8'h63, 1'b1);
        run_until_empty(30, 0);
        check("postrst_grants", 32'(gr_n), 32'd2);
        check("postrst_g0", 32'(gr_id[0]), 32'd0);
        check("postrst_g1", 32'(gr_id[1]), 32'd3);
        check("postrst_d0", 32'(wr_dat[0]), 32'h61);

        // Randomized packets, valid gaps and full back-pressure.
        clear_logs();
        valid_pct = 70;
        total = 0;
        for (int r = 0; r < N; r++) begin
            for (int p = 0; p < 5; p++) begin
                len = int'($urandom_range(12, 1));
                for (int b = 0; b < len; b++) push(r, W'($urandom), b == len - 1);
                total += len;
            end
        end
        run_until_empty(4000, 25);
        check("rand_beats", 32'(wr_n), 32'(total));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
